// File: rtl/cam_req_ctrl_if.sv
// ============================================================================
// cam_req_ctrl_if : command/response handshake bundle for cam_req_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cam_req_ctrl_if #(
  parameter int W = 32,
  parameter int I = 5
);
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [1:0]   cmd_op_i;
  logic [I-1:0] cmd_index_i;
  logic [W-1:0] cmd_data_i;

  logic         resp_valid_o;
  logic         resp_ready_i;
  logic         resp_hit_o;
  logic         resp_new_o;
  logic         resp_full_o;
  logic [I-1:0] resp_index_o;
  logic [W-1:0] resp_data_o;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_index_i, cmd_data_i, resp_ready_i,
    input  cmd_ready_o, resp_valid_o, resp_hit_o, resp_new_o, resp_full_o,
           resp_index_o, resp_data_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_index_i, cmd_data_i, resp_ready_i,
    output cmd_ready_o, resp_valid_o, resp_hit_o, resp_new_o, resp_full_o,
           resp_index_o, resp_data_o
  );
endinterface

`default_nettype wire

// File: rtl/cam_req_ctrl.sv
// ============================================================================
// cam_req_ctrl : CAM request sequencer (lookup / insert-as-search-then-write / read)
// Optional statistics counters enabled by macro CAM_REQ_CTRL_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cam_req_ctrl #(
  parameter  int ARRAY_WIDTH_LOG2 = 5,
  parameter  int ARRAY_SIZE_LOG2  = 5,
  localparam int W = 2**ARRAY_WIDTH_LOG2,
  localparam int I = ARRAY_SIZE_LOG2,
  localparam int N = 2**ARRAY_SIZE_LOG2
) (
  input  logic         clk,
  input  logic         reset,
  cam_req_ctrl_if.slave bus,
  output logic [I:0]   count_o,
  output logic         cam_read_o,
  output logic [I-1:0] cam_read_index_o,
  output logic         cam_write_o,
  output logic [I-1:0] cam_write_index_o,
  output logic [W-1:0] cam_write_data_o,
  output logic         cam_search_o,
  output logic [W-1:0] cam_search_data_o,
  input  logic         cam_read_valid_i,
  input  logic [W-1:0] cam_read_value_i,
  input  logic         cam_search_valid_i,
  input  logic [I-1:0] cam_search_index_i,
  output logic [15:0]  hit_count_o,
  output logic [15:0]  miss_count_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [I:0] FULL_CNT  = (I+1)'(N);

  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [I-1:0] index_q, index_d;
  logic [W-1:0] data_q, data_d;
  logic [I:0]   alloc_q, alloc_d;
  logic         hit_q, hit_d;
  logic         new_q, new_d;
  logic         full_q, full_d;
  logic [I-1:0] rindex_q, rindex_d;
  logic [W-1:0] rdata_q, rdata_d;

  logic cmd_ready, resp_valid, rd_stb, wr_stb, sr_stb;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    index_d    = index_q;
    data_d     = data_q;
    alloc_d    = alloc_q;
    hit_d      = hit_q;
    new_d      = new_q;
    full_d     = full_q;
    rindex_d   = rindex_q;
    rdata_d    = rdata_q;
    cmd_ready  = 1'b0;
    resp_valid = 1'b0;
    rd_stb     = 1'b0;
    wr_stb     = 1'b0;
    sr_stb     = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by reset so the handshake reads 0 while reset is held.
        cmd_ready = ~reset;
        if (bus.cmd_valid_i) begin
          op_d    = bus.cmd_op_i;
          index_d = bus.cmd_index_i;
          data_d  = bus.cmd_data_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        hit_d    = 1'b0;
        new_d    = 1'b0;
        full_d   = 1'b0;
        rindex_d = '0;
        rdata_d  = '0;
        state_d  = RESP;
        case (op_q)
          OP_LOOKUP: begin
            sr_stb   = 1'b1;
            hit_d    = cam_search_valid_i;
            rindex_d = cam_search_index_i;
          end
          OP_READ: begin
            rd_stb   = 1'b1;
            hit_d    = cam_read_valid_i;
            rdata_d  = cam_read_value_i;
            rindex_d = index_q;
          end
          OP_INSERT: begin
            sr_stb = 1'b1;
            if (cam_search_valid_i) begin
              hit_d    = 1'b1;
              rindex_d = cam_search_index_i;
            end else if (alloc_q == FULL_CNT) begin
              full_d = 1'b1;
            end else begin
              state_d = WRITE;
            end
          end
          default: ;
        endcase
      end
      WRITE: begin
        // Linear allocation: entries are never freed, so alloc doubles as occupancy.
        wr_stb   = 1'b1;
        new_d    = 1'b1;
        hit_d    = 1'b0;
        rindex_d = alloc_q[I-1:0];
        alloc_d  = alloc_q + 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      index_q  <= '0;
      data_q   <= '0;
      alloc_q  <= '0;
      hit_q    <= 1'b0;
      new_q    <= 1'b0;
      full_q   <= 1'b0;
      rindex_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      index_q  <= index_d;
      data_q   <= data_d;
      alloc_q  <= alloc_d;
      hit_q    <= hit_d;
      new_q    <= new_d;
      full_q   <= full_d;
      rindex_q <= rindex_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.cmd_ready_o  = cmd_ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_hit_o   = hit_q;
  assign bus.resp_new_o   = new_q;
  assign bus.resp_full_o  = full_q;
  assign bus.resp_index_o = rindex_q;
  assign bus.resp_data_o  = rdata_q;

  assign count_o           = alloc_q;
  assign cam_read_o        = rd_stb;
  assign cam_read_index_o  = index_q;
  assign cam_write_o       = wr_stb;
  assign cam_write_index_o = alloc_q[I-1:0];
  assign cam_write_data_o  = data_q;
  assign cam_search_o      = sr_stb;
  assign cam_search_data_o = data_q;

`ifdef CAM_REQ_CTRL_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        stat_evt;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    stat_evt   = (state_q == RESP) && bus.resp_ready_i &&
                 ((op_q == OP_LOOKUP) || (op_q == OP_INSERT));
    if (stat_evt) begin
      if (hit_q) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  assign hit_count_o  = 16'd0;
  assign miss_count_o = 16'd0;
`endif

endmodule

`default_nettype wire
